// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches in EX, flushes on mispredict, trains 2-bit counters and queues BTB writes.
module branch_resolve_unit #(
  parameter int IDX_BITS = 6,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_pred_hit,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        stall,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [2:0]  write_entry,
  output logic [31:0] btb_pc,
  output logic [31:0] btb_target,
  output logic        btb_taken,
  output logic [15:0] mispredict_cnt
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] ctr [2**IDX_BITS];
  logic [IDX_BITS-1:0] idx;
  logic [1:0] ctr_cur, ctr_upd, enq_cmd, cmd_r;
  logic accept, mispred, enq, deq, new_dir;
  logic [66:0] q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign stall = count == CW'(QDEPTH);
  assign accept = ex_valid & ex_is_branch & ~stall;
  assign idx = ex_pc[IDX_BITS+1:2];
  assign ctr_cur = ctr[idx];
  assign ctr_upd = ex_taken ? (ctr_cur == 2'd3 ? 2'd3 : ctr_cur + 2'd1)
                            : (ctr_cur == 2'd0 ? 2'd0 : ctr_cur - 2'd1);
  assign new_dir = ctr_upd[1];
  // A BTB miss implicitly predicted not-taken at PC+4.
  assign mispred = accept & (((ex_pred_hit & ex_pred_taken) != ex_taken) |
                             (ex_taken & ex_pred_hit & (ex_pred_target != ex_target)));
  assign enq_cmd = ex_pred_hit ? ((new_dir != ex_pred_taken || ex_pred_target != ex_target) ? 2'b01 : 2'b00)
                               : (ex_taken ? 2'b10 : 2'b00);
  assign enq = accept & |enq_cmd;
  assign deq = state == IDLE && count != '0;
  assign write_entry = state == WRITE ? {1'b0, cmd_r} : 3'b000;

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (count != '0 ? WRITE : IDLE) : state == WRITE ? GAP : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < 2**IDX_BITS; i++) ctr[i] <= 2'b01;
      flush <= 1'b0;
      redirect_pc <= '0;
      mispredict_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cmd_r <= '0;
      btb_pc <= '0;
      btb_target <= '0;
      btb_taken <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) ctr[idx] <= ctr_upd;
      flush <= mispred;
      if (mispred) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
      if (mispred && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
      if (deq) {cmd_r, btb_pc, btb_target, btb_taken} <= q_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr] <= {enq_cmd, ex_pc, ex_target, new_dir};
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int QD = 2;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_hit = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic stall, flush, btb_taken;
  logic [31:0] redirect_pc, btb_pc, btb_target;
  logic [2:0] write_entry;
  logic [15:0] mispredict_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.IDX_BITS(6), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken), .ex_pred_hit(ex_pred_hit),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .stall(stall),
    .flush(flush), .redirect_pc(redirect_pc), .write_entry(write_entry), .btb_pc(btb_pc),
    .btb_target(btb_target), .btb_taken(btb_taken), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {logic [1:0] cmd; logic [31:0] pc; logic [31:0] tgt; logic dir;} ent_t;
  ent_t q[$];
  int ctr[64];
  int last_pop, edge_n;
  logic m_flush, m_btk, m_stall;
  logic [31:0] m_redir, m_bpc, m_btgt;
  logic [15:0] m_cnt;
  logic [2:0] m_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    q.delete();
    foreach (ctr[i]) ctr[i] = 1;
    last_pop = -10;
    edge_n = 0;
    {m_flush, m_btk, m_stall, m_redir, m_bpc, m_btgt, m_cnt, m_we} = '0;
  endtask

  task automatic check_outputs;
    check("stall", stall, m_stall);
    check("flush", flush, m_flush);
    if (m_flush) check("redirect_pc", redirect_pc, m_redir);
    check("write_entry", write_entry, m_we);
    check("btb_pc", btb_pc, m_bpc);
    check("btb_target", btb_target, m_btgt);
    check("btb_taken", btb_taken, m_btk);
    check("mispredict_cnt", mispredict_cnt, m_cnt);
  endtask

  task automatic cycle(input logic v, input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic ph, input logic pt, input logic [31:0] ptgt);
    ent_t e;
    int nw;
    logic dir;
    logic [1:0] cmd;
    @(negedge clk);
    check_outputs();
    {ex_valid, ex_is_branch, ex_pc, ex_target, ex_taken} = {v, br, pc, tgt, tk};
    {ex_pred_hit, ex_pred_taken, ex_pred_target} = {ph, pt, ptgt};
    m_we = 3'b000;
    if (q.size() > 0 && edge_n >= last_pop + 3) begin
      e = q.pop_front();
      m_we = {1'b0, e.cmd};
      {m_bpc, m_btgt, m_btk} = {e.pc, e.tgt, e.dir};
      last_pop = edge_n;
    end
    m_flush = 0;
    if (v && br && !m_stall) begin
      nw = tk ? (ctr[pc[7:2]] == 3 ? 3 : ctr[pc[7:2]] + 1) : (ctr[pc[7:2]] == 0 ? 0 : ctr[pc[7:2]] - 1);
      ctr[pc[7:2]] = nw;
      dir = nw >= 2;
      if (((ph && pt) != tk) || (tk && ph && ptgt != tgt)) begin
        m_flush = 1;
        m_redir = tk ? tgt : pc + 32'd4;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      cmd = ph ? ((dir != pt || ptgt != tgt) ? 2'b01 : 2'b00) : (tk ? 2'b10 : 2'b00);
      if (cmd != 0) q.push_back('{cmd, pc, tgt, dir});
    end
    m_stall = q.size() == QD;
    edge_n++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic held(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic ph, input logic pt, input logic [31:0] ptgt);
    int guard = 0;
    while (m_stall && guard < 20) begin
      cycle(1, 1, pc, tgt, tk, ph, pt, ptgt);
      guard++;
    end
    check("stall_bound", guard < 20, 1);
    cycle(1, 1, pc, tgt, tk, ph, pt, ptgt);
  endtask

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] tgts [4];
    logic [31:0] rp, rt, rpt;
    logic rv, rb, rk, rh, rpk;
    int guard;
    pcs = '{32'h40, 32'h44, 32'h100, 32'h200, 32'hFFFF_FFFC};
    tgts = '{32'h80, 32'h400, 32'h0, 32'h1234_5678};
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    held(32'h40, 32'h80, 1, 0, 0, 0);
    idle(4);
    held(32'h40, 32'h80, 1, 1, 1, 32'h80);
    held(32'h40, 32'h80, 1, 1, 1, 32'h80);
    idle(3);
    held(32'h40, 32'h80, 0, 1, 1, 32'h80);
    held(32'h40, 32'h80, 0, 1, 1, 32'h80);
    idle(4);
    for (int i = 0; i < 3; i++) held(32'h100 + 32'(4 * i), 32'h300, 1, 0, 0, 0);
    idle(10);
    held(32'h500, 32'h600, 1, 0, 0, 0);
    guard = 0;
    while (m_we == 0 && guard < 10) begin
      idle(1);
      guard++;
    end
    check("write_seen", guard < 10, 1);
    #2 rst_n = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    idle(5);
    held(32'hFFFF_FFFC, 32'h800, 0, 1, 1, 32'h800);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall) begin
        rv = $urandom_range(0, 3) != 0;
        rb = $urandom_range(0, 5) != 0;
        rp = pcs[$urandom_range(0, 4)];
        rt = tgts[$urandom_range(0, 3)];
        rk = $urandom_range(0, 1);
        rh = $urandom_range(0, 1);
        rpk = $urandom_range(0, 1);
        rpt = $urandom_range(0, 3) == 0 ? tgts[$urandom_range(0, 3)] : rt;
      end
      cycle(rv, rb, rp, rt, rk, rh, rpk, rpt);
    end
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
